// File: rtl/nios_qsys_debug_pkg.sv
// Shared types and default parameters for the Nios II debug command queue.
package nios_qsys_debug_pkg;

  localparam int DATA_W_DEF      = 38;
  localparam int IR_W_DEF        = 2;
  localparam int ACT_BIT_DEF     = 34;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int GAP_DEF         = 1;

  // Dispatcher states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    HOLD     = 2'd2
  } state_e;

  // One queued command at the default widths: IR channel above the scan word
  typedef struct packed {
    logic [IR_W_DEF-1:0]   ch;
    logic [DATA_W_DEF-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/nios_qsys_debug_cmd_fifo.sv
// Small register FIFO holding {ch, data} debug commands. Counters carry one
// extra bit so full and empty are distinguishable; push on a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module nios_qsys_debug_cmd_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  fill
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]  wr_cnt_q, wr_cnt_d;
  logic [AW:0]  rd_cnt_q, rd_cnt_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign fill    = wr_cnt_q - rd_cnt_q;
  assign full    = (fill == FULL_CNT);
  assign empty   = (fill == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_cnt_q[AW-1:0]];

  // Advance the wrapping read/write counters
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (push_ok) wr_cnt_d = wr_cnt_q + 1'b1;
    if (pop_ok)  rd_cnt_d = rd_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset so queued commands are discarded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Storage write; contents need no reset since the counters gate visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_cnt_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/nios_qsys_nios2_gen2_cpu_debug_cmd_queue.sv
// Sysclk-side debug command dispatcher: synchronises the JTAG update-DR
// toggle, queues {ir, sr} commands and issues one-cycle per-channel strobes
// in strict arrival order, honouring per-channel ready and an inter-dispatch gap.
module nios_qsys_nios2_gen2_cpu_debug_cmd_queue
  import nios_qsys_debug_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int GAP         = GAP_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         udr_toggle,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [DATA_W-1:0]            sr,
  input  logic [2**IR_W-1:0]           ch_ready,
  input  logic                         ovf_clr,
  output logic [DATA_W-1:0]            jdo,
  output logic [IR_W-1:0]              jdo_ch,
  output logic [2**IR_W-1:0]           take_action,
  output logic [2**IR_W-1:0]           take_no_action,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         overflow
);

  localparam int NUM_CH  = 2**IR_W;
  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam int HOLD_W  = (GAP > 1) ? $clog2(GAP) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;
  logic [PRIME_W-1:0]     prime_cnt_q, prime_cnt_d;
  logic                   priming;

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [IR_W-1:0]        jdo_ch_q, jdo_ch_d;
  logic [NUM_CH-1:0]      act_q, act_d;
  logic [NUM_CH-1:0]      noact_q, noact_d;
  logic                   ovf_q, ovf_d;

  logic [IR_W+DATA_W-1:0] head;
  logic [IR_W-1:0]        head_ch;
  logic [DATA_W-1:0]      head_data;
  logic                   fifo_full, fifo_empty;
  logic                   head_ready;
  logic                   pop_c;
  logic                   drop;
  logic [NUM_CH-1:0]      head_onehot;

  // Synchroniser shift chain: stage 0 samples the async toggle
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = udr_toggle;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign priming  = (int'(prime_cnt_q) < SYNC_STAGES + 1);

  // Edge detect, suppressed while the chain primes after reset
  always_comb begin
    prime_cnt_d = priming ? prime_cnt_q + 1'b1 : prime_cnt_q;
    prev_d      = sync_out;
    edge_d      = ~priming & (sync_out ^ prev_q);
  end

  nios_qsys_debug_cmd_fifo #(
    .W     (IR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (edge_q),
    .push_data ({ir_in, sr}),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign {head_ch, head_data} = head;
  assign head_ready  = ~fifo_empty & ch_ready[head_ch];
  assign head_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << head_ch;
  assign drop        = edge_q & fifo_full & ~pop_c;

  // All state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      edge_q      <= 1'b0;
      prime_cnt_q <= '0;
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      jdo_q       <= '0;
      jdo_ch_q    <= '0;
      act_q       <= '0;
      noact_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      edge_q      <= edge_d;
      prime_cnt_q <= prime_cnt_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      jdo_q       <= jdo_d;
      jdo_ch_q    <= jdo_ch_d;
      act_q       <= act_d;
      noact_q     <= noact_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next state and pop decision; the last HOLD cycle re-tests the head so
  // dispatches land exactly GAP+1 cycles apart
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pop_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (head_ready) begin
          pop_c   = 1'b1;
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        if (GAP == 0) begin
          if (head_ready) begin
            pop_c   = 1'b1;
            state_d = DISPATCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (int'(hold_cnt_q) >= GAP - 1) begin
          if (head_ready) begin
            pop_c   = 1'b1;
            state_d = DISPATCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output data: load jdo on pop, raise the matching strobe, track overflow
  always_comb begin
    jdo_d    = jdo_q;
    jdo_ch_d = jdo_ch_q;
    act_d    = '0;
    noact_d  = '0;
    ovf_d    = ovf_q;
    if (pop_c) begin
      jdo_d    = head_data;
      jdo_ch_d = head_ch;
      if (head_data[ACT_BIT]) act_d   = head_onehot;
      else                    noact_d = head_onehot;
    end
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  assign jdo            = jdo_q;
  assign jdo_ch         = jdo_ch_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_nios_qsys_nios2_gen2_cpu_debug_cmd_queue.sv
// Bench for the debug command queue: directed scenarios plus a randomized
// phase, checked against an in-order command queue model.
module tb_nios_qsys_nios2_gen2_cpu_debug_cmd_queue;
  import nios_qsys_debug_pkg::*;

  localparam int GAP   = 1;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        udr_toggle;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [3:0]  ch_ready;
  logic        ovf_clr;
  logic [37:0] jdo;
  logic [1:0]  jdo_ch;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fill;
  logic        overflow;

  logic        tog0, ovf_clr0;
  logic [1:0]  ir0;
  logic [37:0] sr0;
  logic [3:0]  ch_ready0;
  logic [37:0] jdo0;
  logic [1:0]  jdo_ch0;
  logic [3:0]  act0, noact0;
  logic [2:0]  fill0;
  logic        ovf0;

  always #5 clk = ~clk;

  nios_qsys_nios2_gen2_cpu_debug_cmd_queue #(.GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .udr_toggle(udr_toggle), .ir_in(ir_in), .sr(sr),
    .ch_ready(ch_ready), .ovf_clr(ovf_clr), .jdo(jdo), .jdo_ch(jdo_ch),
    .take_action(take_action), .take_no_action(take_no_action), .fill(fill),
    .overflow(overflow)
  );

  nios_qsys_nios2_gen2_cpu_debug_cmd_queue #(.GAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .udr_toggle(tog0), .ir_in(ir0), .sr(sr0),
    .ch_ready(ch_ready0), .ovf_clr(ovf_clr0), .jdo(jdo0), .jdo_ch(jdo_ch0),
    .take_action(act0), .take_no_action(noact0), .fill(fill0), .overflow(ovf0)
  );

  int         ncomp = 0;
  int         nfail = 0;
  int         cyc = 0;
  cmd_entry_t model_q[$];
  int         strobe_cnt = 0;
  int         strobe_cycs[$];
  int         last_strobe_cyc = -100;
  logic [3:0] last_act = '0;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding command
  always @(negedge clk) begin : monitor
    cmd_entry_t e;
    logic [3:0] oh;
    if (mon_en && reset_n === 1'b1 && ((take_action | take_no_action) !== 4'b0)) begin
      strobe_cnt++;
      strobe_cycs.push_back(cyc);
      check("strobe_spacing", 64'(cyc - last_strobe_cyc >= GAP + 1), 64'd1);
      last_strobe_cyc = cyc;
      last_act = take_action;
      check("model_has_cmd", 64'(model_q.size() != 0), 64'd1);
      if (model_q.size() != 0) begin
        e  = model_q.pop_front();
        oh = 4'b0001 << e.ch;
        $display("strobe cyc=%0d ch=%0d act=%b noact=%b jdo=%h", cyc, jdo_ch, take_action, take_no_action, jdo);
        check("strobe_jdo", 64'(jdo), 64'(e.data));
        check("strobe_ch", 64'(jdo_ch), 64'(e.ch));
        check("strobe_act", 64'(take_action), e.data[34] ? 64'(oh) : 64'd0);
        check("strobe_noact", 64'(take_no_action), e.data[34] ? 64'd0 : 64'(oh));
        check("strobe_ready", 64'(ch_ready[e.ch]), 64'd1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [37:0] rnd38();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[37:0];
  endfunction

  // Flip the toggle and record the command unless the queue would overflow
  task automatic flip(input logic [1:0] ch, input logic [37:0] d);
    cmd_entry_t e;
    ir_in = ch;
    sr = d;
    udr_toggle = ~udr_toggle;
    e.ch = ch;
    e.data = d;
    if (model_q.size() < DEPTH) model_q.push_back(e);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    for (int i = 0; i < budget && strobe_cnt < target; i++) step();
  endtask

  initial begin
    int n, c0, since;
    logic [37:0] d;
    reset_n = 1'b0; udr_toggle = 1'b1; ir_in = '0; sr = '0; ch_ready = '0; ovf_clr = 1'b0;
    tog0 = 1'b0; ir0 = 2'd3; sr0 = '0; ch_ready0 = '0; ovf_clr0 = 1'b0;
    steps(3);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // 1: toggle high through reset must not create a command
    steps(10);
    check("t1_no_strobe", 64'(strobe_cnt), 64'd0);
    check("t1_fill", 64'(fill), 64'd0);
    check("t1_overflow", 64'(overflow), 64'd0);
    check("t1_jdo", 64'(jdo), 64'd0);

    // 2: single action command, latency and one-cycle strobe
    ch_ready = 4'hF;
    steps(2);
    c0 = cyc;
    n = strobe_cnt;
    flip(2'd2, 38'h4_0000_0001);
    wait_strobes(n + 1, 20);
    check("t2_seen", 64'(strobe_cnt), 64'(n + 1));
    check("t2_latency", 64'(strobe_cycs[strobe_cycs.size()-1]), 64'(c0 + 5));
    check("t2_act", 64'(last_act), 64'h4);
    check("t2_jdo", 64'(jdo), 64'h4_0000_0001);
    check("t2_ch", 64'(jdo_ch), 64'd2);
    step();
    check("t2_one_cycle", 64'(take_action), 64'd0);

    // 3: fill to DEPTH, overflow on fifth, clear, drain with fixed spacing
    ch_ready = 4'h0;
    for (int i = 0; i < 5; i++) begin
      d = rnd38();
      flip(2'(i), d);
      steps(6);
    end
    check("t3_fill", 64'(fill), 64'd4);
    check("t3_overflow", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 64'(overflow), 64'd0);
    strobe_cycs.delete();
    n = strobe_cnt;
    ch_ready = 4'hF;
    wait_strobes(n + 4, 40);
    check("t3_drain", 64'(strobe_cnt), 64'(n + 4));
    for (int i = 1; i < 4; i++)
      check("t3_spacing", 64'(strobe_cycs[i] - strobe_cycs[i-1]), 64'(GAP + 1));
    check("t3_fill_empty", 64'(fill), 64'd0);

    // 4: blocked head channel stalls later commands
    ch_ready = 4'b1101;
    flip(2'd1, rnd38());
    steps(6);
    flip(2'd0, rnd38());
    steps(6);
    n = strobe_cnt;
    steps(10);
    check("t4_blocked", 64'(strobe_cnt), 64'(n));
    check("t4_fill", 64'(fill), 64'd2);
    ch_ready = 4'hF;
    wait_strobes(n + 2, 20);
    check("t4_released", 64'(strobe_cnt), 64'(n + 2));
    check("t4_last_ch", 64'(jdo_ch), 64'd0);

    // 5: GAP=0 instance issues back-to-back no-action strobes
    for (int i = 0; i < 3; i++) begin
      d = rnd38();
      d[34] = 1'b0;
      sr0 = d;
      tog0 = ~tog0;
      steps(6);
    end
    check("t5_fill", 64'(fill0), 64'd3);
    ch_ready0 = 4'hF;
    for (int i = 0; i < 20 && noact0 == 4'b0; i++) step();
    for (int i = 0; i < 3; i++) begin
      check("t5_noact", 64'(noact0), 64'h8);
      check("t5_act", 64'(act0), 64'd0);
      step();
    end
    check("t5_end", 64'(noact0), 64'd0);

    // Randomized phase: random readiness, random commands, never overfilling
    since = 10;
    for (int it = 0; it < 200; it++) begin
      ch_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      if (since >= 5 && model_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
        flip(2'($urandom_range(0, 3)), rnd38());
        since = 0;
      end
      step();
      since++;
      if (it % 20 == 19) check("rand_fill_bound", 64'(int'(fill) <= model_q.size()), 64'd1);
    end
    ch_ready = 4'hF;
    for (int i = 0; i < 60 && model_q.size() != 0; i++) step();
    steps(2);
    check("rand_drained", 64'(model_q.size()), 64'd0);
    check("rand_fill", 64'(fill), 64'd0);
    check("rand_overflow", 64'(overflow), 64'd0);

    // 6: reset with queued commands clears outputs and queue
    ch_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      flip(2'(i), rnd38() | 38'h1);
      steps(6);
    end
    check("t6_fill", 64'(fill), 64'd3);
    n = strobe_cnt;
    reset_n = 1'b0;
    #1;
    check("t6_rst_fill", 64'(fill), 64'd0);
    check("t6_rst_jdo", 64'(jdo), 64'd0);
    check("t6_rst_ch", 64'(jdo_ch), 64'd0);
    check("t6_rst_strobes", 64'(take_action | take_no_action), 64'd0);
    model_q.delete();
    steps(2);
    reset_n = 1'b1;
    ch_ready = 4'hF;
    steps(15);
    check("t6_no_strobe", 64'(strobe_cnt), 64'(n));
    check("t6_fill_after", 64'(fill), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
